// File: rtl/rv_pipe_pkg.sv
// Shared pipeline constants for the decode-stage hazard logic.
package rv_pipe_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // Stage index of each tag-pipeline entry past decode
  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  // Field layout of one in-flight destination tag
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              is_load;
  } tag_entry_t;

endpackage

// File: rtl/fwd_src_select.sv
// Per-operand priority matcher: picks the youngest in-flight producer of rs,
// or falls back to register file data. Flags a match whose value is not
// available yet so the top can stall.
module fwd_src_select
  import rv_pipe_pkg::*;
#(
  parameter int XLEN       = rv_pipe_pkg::XLEN,
  parameter int REG_AW     = rv_pipe_pkg::REG_AW,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = STG_MEM,
  parameter int SRC_W      = $clog2(DEPTH + 1)
) (
  input  logic [REG_AW-1:0]       rs,
  input  logic [XLEN-1:0]         rf_rdata,
  input  logic [DEPTH-1:0]        tag_valid,
  input  logic [DEPTH*REG_AW-1:0] tag_rd,
  input  logic [DEPTH-1:0]        tag_we,
  input  logic [DEPTH-1:0]        tag_load,
  input  logic [DEPTH*XLEN-1:0]   st_value,
  output logic [XLEN-1:0]         value,
  output logic [SRC_W-1:0]        src,
  output logic                    not_ready
);

  // Scan oldest to youngest so the lowest matching entry is written last and wins
  always_comb begin
    value     = rf_rdata;
    src       = '0;
    not_ready = 1'b0;
    if (rs == '0) begin
      value = '0;
    end else begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (tag_valid[k] && tag_we[k] && (tag_rd[k*REG_AW +: REG_AW] == rs)) begin
          src = SRC_W'(k + 1);
          if (tag_load[k] && (k < LOAD_STAGE)) begin
            value     = rf_rdata;
            not_ready = 1'b1;
          end else begin
            value     = st_value[k*XLEN +: XLEN];
            not_ready = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Decode-stage RAW hazard unit: tracks destination tags of in-flight
// instructions, resolves rs1/rs2 by forwarding, and raises load-use stalls.
// Bubbles keep the decode rd/we/is_load fields but clear valid, so only
// valid gates matching.
module hazard_forward_unit
  import rv_pipe_pkg::*;
#(
  parameter int XLEN       = rv_pipe_pkg::XLEN,
  parameter int REG_AW     = rv_pipe_pkg::REG_AW,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = STG_MEM,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic [REG_AW-1:0]             id_rs1,
  input  logic [REG_AW-1:0]             id_rs2,
  input  logic [REG_AW-1:0]             id_rd,
  input  logic                          id_rd_we,
  input  logic                          id_is_load,
  input  logic [XLEN-1:0]               id_rs1_rdata,
  input  logic [XLEN-1:0]               id_rs2_rdata,
  input  logic                          flush,
  input  logic [DEPTH*XLEN-1:0]         st_value,
  output logic [XLEN-1:0]               rs1_value,
  output logic [XLEN-1:0]               rs2_value,
  output logic [$clog2(DEPTH+1)-1:0]    rs1_src,
  output logic [$clog2(DEPTH+1)-1:0]    rs2_src,
  output logic                          stall,
  output logic [CNT_W-1:0]              stall_cnt,
  output logic [CNT_W-1:0]              fwd_cnt
);

  localparam int SRC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]        tag_valid;
  logic [DEPTH*REG_AW-1:0] tag_rd;
  logic [DEPTH-1:0]        tag_we;
  logic [DEPTH-1:0]        tag_load;
  logic                    rs1_not_ready;
  logic                    rs2_not_ready;
  logic                    issue;
  logic                    fwd_fire;

  fwd_src_select #(
    .XLEN(XLEN), .REG_AW(REG_AW), .DEPTH(DEPTH),
    .LOAD_STAGE(LOAD_STAGE), .SRC_W(SRC_W)
  ) u_sel_rs1 (
    .rs(id_rs1), .rf_rdata(id_rs1_rdata),
    .tag_valid(tag_valid), .tag_rd(tag_rd), .tag_we(tag_we), .tag_load(tag_load),
    .st_value(st_value),
    .value(rs1_value), .src(rs1_src), .not_ready(rs1_not_ready)
  );

  fwd_src_select #(
    .XLEN(XLEN), .REG_AW(REG_AW), .DEPTH(DEPTH),
    .LOAD_STAGE(LOAD_STAGE), .SRC_W(SRC_W)
  ) u_sel_rs2 (
    .rs(id_rs2), .rf_rdata(id_rs2_rdata),
    .tag_valid(tag_valid), .tag_rd(tag_rd), .tag_we(tag_we), .tag_load(tag_load),
    .st_value(st_value),
    .value(rs2_value), .src(rs2_src), .not_ready(rs2_not_ready)
  );

  // Flush overrides stall: the squashed instruction never needs its operands
  assign stall    = id_valid && !flush && (rs1_not_ready || rs2_not_ready);
  assign issue    = id_valid && !stall && !flush;
  assign fwd_fire = id_valid && !stall && ((rs1_src != '0) || (rs2_src != '0));

  // Tag pipeline: entry 0 takes the decode slot (or a bubble), older entries shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= '0;
      tag_rd    <= '0;
      tag_we    <= '0;
      tag_load  <= '0;
    end else begin
      tag_valid[STG_EX]          <= issue;
      tag_rd[0 +: REG_AW]        <= id_rd;
      tag_we[STG_EX]             <= id_rd_we && (id_rd != '0);
      tag_load[STG_EX]           <= id_is_load;
      for (int k = 1; k < DEPTH; k++) begin
        tag_valid[k]                <= tag_valid[k-1];
        tag_rd[k*REG_AW +: REG_AW]  <= tag_rd[(k-1)*REG_AW +: REG_AW];
        tag_we[k]                   <= tag_we[k-1];
        tag_load[k]                 <= tag_load[k-1];
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (fwd_fire && (fwd_cnt != '1)) fwd_cnt <= fwd_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: a cycle-by-cycle vector table
// starting from reset, then hand-written reset and counter-saturation runs.
// The counters are instanced narrow so saturation is reached quickly.
module tb_hazard_forward_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 10;
  localparam logic [31:0] RD1 = 32'h0000_0011;
  localparam logic [31:0] RD2 = 32'h0000_0022;
  localparam logic [31:0] S0  = 32'h0000_AAAA;
  localparam logic [31:0] S1  = 32'h0000_DEAD;
  localparam logic [31:0] S2  = 32'h2222_2222;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             id_rd_we, id_is_load;
  logic [31:0]      id_rs1_rdata, id_rs2_rdata;
  logic             flush;
  logic [95:0]      st_value;
  logic [31:0]      rs1_value, rs2_value;
  logic [1:0]       rs1_src, rs2_src;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt, fwd_cnt;

  hazard_forward_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rd_we(id_rd_we), .id_is_load(id_is_load),
    .id_rs1_rdata(id_rs1_rdata), .id_rs2_rdata(id_rs2_rdata),
    .flush(flush), .st_value(st_value),
    .rs1_value(rs1_value), .rs2_value(rs2_value),
    .rs1_src(rs1_src), .rs2_src(rs2_src), .stall(stall),
    .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic        we, ld, fl;
    logic [31:0] e_v1, e_v2;
    logic [1:0]  e_s1, e_s2;
    logic        e_stall;
    int          e_scnt, e_fcnt;
  } vec_t;

  int n_vec  = 0;
  int n_chk  = 0;
  int n_fail = 0;
  vec_t tbl[15];

  function automatic vec_t mk(logic valid, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic we, logic ld, logic fl, logic [31:0] e_v1, logic [31:0] e_v2,
                              logic [1:0] e_s1, logic [1:0] e_s2, logic e_stall,
                              int e_scnt, int e_fcnt);
    vec_t v;
    v.valid = valid; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.we = we; v.ld = ld; v.fl = fl;
    v.e_v1 = e_v1; v.e_v2 = e_v2; v.e_s1 = e_s1; v.e_s2 = e_s2;
    v.e_stall = e_stall; v.e_scnt = e_scnt; v.e_fcnt = e_fcnt;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic valid, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                       logic we, logic ld, logic fl);
    id_valid = valid; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rd_we = we; id_is_load = ld; flush = fl;
    n_vec++;
  endtask

  // Watchdog so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // cycle-by-cycle script from reset; comments give entries E0/E1/E2 before the cycle
    tbl[0]  = mk(1, 5, 6, 3, 1, 0, 0, RD1, RD2, 0, 0, 0, 0, 0);  // empty
    tbl[1]  = mk(1, 3, 0, 4, 1, 0, 0, S0,  0,   1, 0, 0, 0, 1);  // E0=r3 back-to-back
    tbl[2]  = mk(1, 9, 3, 4, 1, 0, 0, RD1, S1,  0, 2, 0, 0, 2);  // E0=r4 E1=r3
    tbl[3]  = mk(1, 4, 3, 0, 1, 0, 0, S0,  S2,  1, 3, 0, 0, 3);  // r4 in E0,E1: youngest; r3 in WB
    tbl[4]  = mk(1, 0, 4, 7, 1, 1, 0, 0,   S1,  0, 2, 0, 0, 4);  // E0=r0 producer, rs1=x0
    tbl[5]  = mk(1, 1, 7, 8, 1, 0, 0, RD1, RD2, 0, 1, 1, 1, 4);  // E0=load r7 -> stall
    tbl[6]  = mk(1, 1, 7, 8, 1, 0, 0, RD1, S1,  0, 2, 0, 1, 5);  // load now in E1
    tbl[7]  = mk(1, 7, 2, 5, 1, 0, 0, S2,  RD2, 3, 0, 0, 1, 6);  // load r7 forwarded from WB
    tbl[8]  = mk(1, 0, 0, 9, 1, 1, 0, 0,   0,   0, 0, 0, 1, 6);  // issue load r9
    tbl[9]  = mk(1, 9, 0, 10, 1, 0, 1, RD1, 0,  1, 0, 0, 1, 7);  // flush in load-use cycle
    tbl[10] = mk(1, 10, 9, 11, 1, 0, 0, RD1, S1, 0, 2, 0, 1, 8); // E0 bubble with stale r10
    tbl[11] = mk(0, 10, 9, 0, 0, 0, 0, RD1, S2, 0, 3, 0, 1, 8);  // id invalid: no count
    tbl[12] = mk(1, 11, 11, 0, 0, 0, 0, S1, S1, 2, 2, 0, 1, 9);  // both operands from E1
    tbl[13] = mk(1, 0, 0, 12, 1, 1, 0, 0,   0,  0, 0, 0, 1, 9);  // issue load r12
    tbl[14] = mk(0, 12, 0, 0, 0, 0, 0, RD1, 0,  1, 0, 0, 1, 9);  // invalid decode never stalls

    st_value     = {S2, S1, S0};
    id_rs1_rdata = RD1;
    id_rs2_rdata = RD2;
    rst_n        = 1'b0;
    drive(0, 5, 0, 0, 0, 0, 0);
    #12;
    chk("reset_rs1_value", rs1_value, RD1);
    chk("reset_rs1_src", rs1_src, 0);
    chk("reset_rs2_value_x0", rs2_value, 0);
    chk("reset_stall", stall, 0);
    chk("reset_stall_cnt", stall_cnt, 0);
    chk("reset_fwd_cnt", fwd_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].valid, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].we, tbl[i].ld, tbl[i].fl);
      @(negedge clk);
      chk($sformatf("v%0d_rs1_value", i), rs1_value, tbl[i].e_v1);
      chk($sformatf("v%0d_rs2_value", i), rs2_value, tbl[i].e_v2);
      chk($sformatf("v%0d_rs1_src", i), rs1_src, tbl[i].e_s1);
      chk($sformatf("v%0d_rs2_src", i), rs2_src, tbl[i].e_s2);
      chk($sformatf("v%0d_stall", i), stall, tbl[i].e_stall);
      @(posedge clk); #1;
      chk($sformatf("v%0d_stall_cnt", i), stall_cnt, CNT_W'(tbl[i].e_scnt));
      chk($sformatf("v%0d_fwd_cnt", i), fwd_cnt, CNT_W'(tbl[i].e_fcnt));
    end

    // Mid-stream reset: a live producer of r3 must be forgotten
    drive(1, 0, 0, 3, 1, 0, 0);
    @(posedge clk); #1;
    drive(0, 3, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("pre_reset_fwd_src", rs1_src, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_rs1_src", rs1_src, 0);
    chk("async_reset_rs1_value", rs1_value, RD1);
    chk("async_reset_stall_cnt", stall_cnt, 0);
    chk("async_reset_fwd_cnt", fwd_cnt, 0);
    @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    drive(0, 5, 3, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("post_reset_rs1_value", rs1_value, RD1);
    chk("post_reset_rs1_src", rs1_src, 0);
    chk("post_reset_rs2_src_stale", rs2_src, 0);
    chk("post_reset_rs2_value", rs2_value, RD2);
    chk("post_reset_stall", stall, 0);
    chk("post_reset_fwd_cnt", fwd_cnt, 0);

    // Counter saturation: repeated load-use pairs, one stall each
    for (int i = 0; i < (1 << CNT_W) + 6; i++) begin
      drive(1, 0, 0, 7, 1, 1, 0);
      @(posedge clk); #1;
      drive(1, 0, 7, 0, 0, 0, 0);
      if (i == 0) begin
        @(negedge clk);
        chk("sat_first_stall", stall, 1);
      end
      @(posedge clk); #1;
      if (i == 999) chk("sat_stall_cnt_1000", stall_cnt, 1000);
    end
    chk("sat_stall_cnt_max", stall_cnt, {CNT_W{1'b1}});
    chk("sat_fwd_cnt_zero", fwd_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
